// File: rtl/evr_dbus_monitor_if.sv
// Distributed-bus sample channel: decoded byte and qualifier from the
// receiver, plus the byte as held by the monitor.
interface evr_dbus_monitor_if #(
    parameter int DISTRIBUTED_BUS_WIDTH = 8
);
    logic [DISTRIBUTED_BUS_WIDTH-1:0] evrDbus;
    logic                             evrDbusValid;
    logic [DISTRIBUTED_BUS_WIDTH-1:0] evrDbusLatched;

    modport master (
        output evrDbus,
        output evrDbusValid,
        input  evrDbusLatched
    );

    modport slave (
        input  evrDbus,
        input  evrDbusValid,
        output evrDbusLatched
    );
endinterface

// File: rtl/evr_dbus_monitor.sv
// Receive-side distributed-bus monitor: recovers the heartbeat (bit 0),
// ping square wave (bit 1) and diagnostic level (bit 2), and reports
// heartbeat markers/interval/lock/loss and ping edge/half-period/lock.
module evr_dbus_monitor #(
    parameter int  RXCLK_NOMINAL_FREQUENCY = 125000000,
    parameter int  DISTRIBUTED_BUS_WIDTH   = 8,
    parameter int  HB_TIMEOUT_CYCLES       = 5 * RXCLK_NOMINAL_FREQUENCY,
    parameter int  PING_TOLERANCE          = 8,
    localparam int HB_W      = $clog2(RXCLK_NOMINAL_FREQUENCY) + 3,
    localparam int PING_HALF = RXCLK_NOMINAL_FREQUENCY / 200000,
    localparam int PING_W    = $clog2(PING_HALF) + 2
) (
    input  logic              evrRxClk,
    input  logic              evrRxReset,
    evr_dbus_monitor_if.slave dbus,
    output logic              evrHeartbeatMarker,
    output logic              evrHeartbeatLocked,
    output logic [HB_W-1:0]   evrHeartbeatInterval,
    output logic [7:0]        evrHeartbeatLossCount,
    output logic              evrPing,
    output logic              evrPingEdge,
    output logic              evrPingLocked,
    output logic [PING_W-1:0] evrPingHalfPeriod,
    output logic              evrDiag
);
    typedef enum logic [1:0] {LOST, ACQUIRE, LOCKED} hbState_t;

    hbState_t                         hbState, hbStateNext;
    logic [DISTRIBUTED_BUS_WIDTH-1:0] latched;
    logic [HB_W-1:0]                  hbCnt;
    logic [PING_W-1:0]                pCnt;
    logic [1:0]                       pGood;

    logic            hbRise, pEdge, hbTimeout, pTimeout, pInTol;
    logic [HB_W:0]   hbMeas;
    logic [PING_W:0] pMeas;

    // Edges compare the incoming bit with the held bit, so only valid
    // cycles can ever produce one.
    assign hbRise = dbus.evrDbusValid & dbus.evrDbus[0] & ~latched[0];
    assign pEdge  = dbus.evrDbusValid & (dbus.evrDbus[1] ^ latched[1]);

    // Measured lengths include the current cycle (counter + 1), one bit
    // wider so a saturated counter never wraps to a small value.
    assign hbMeas    = {1'b0, hbCnt} + (HB_W+1)'(1);
    assign pMeas     = {1'b0, pCnt} + (PING_W+1)'(1);
    assign hbTimeout = hbMeas >= (HB_W+1)'(HB_TIMEOUT_CYCLES);
    assign pTimeout  = pMeas >= (PING_W+1)'(2 * PING_HALF);
    assign pInTol    = (({1'b0, pMeas} + (PING_W+2)'(PING_TOLERANCE)) >= (PING_W+2)'(PING_HALF))
                    && (pMeas <= (PING_W+1)'(PING_HALF + PING_TOLERANCE));

    assign dbus.evrDbusLatched = latched;
    assign evrPing             = latched[1];
    assign evrDiag             = latched[2];

    // Bus sample register.
    always_ff @(posedge evrRxClk) begin
        if (evrRxReset)             latched <= '0;
        else if (dbus.evrDbusValid) latched <= dbus.evrDbus;
    end

    // Heartbeat state register.
    always_ff @(posedge evrRxClk) begin
        if (evrRxReset) hbState <= LOST;
        else            hbState <= hbStateNext;
    end

    // Heartbeat next state: a rising edge always beats a same-cycle timeout.
    always_comb begin
        hbStateNext = hbState;
        case (hbState)
            LOST:            if (hbRise) hbStateNext = ACQUIRE;
            ACQUIRE, LOCKED: if (hbRise)         hbStateNext = LOCKED;
                             else if (hbTimeout) hbStateNext = LOST;
            default:         hbStateNext = LOST;
        endcase
    end

    // Heartbeat counter, marker, interval, lock flag and loss statistics.
    always_ff @(posedge evrRxClk) begin
        if (evrRxReset) begin
            hbCnt                 <= '0;
            evrHeartbeatMarker    <= 1'b0;
            evrHeartbeatLocked    <= 1'b0;
            evrHeartbeatInterval  <= '0;
            evrHeartbeatLossCount <= '0;
        end else begin
            evrHeartbeatMarker <= hbRise;
            evrHeartbeatLocked <= (hbStateNext == LOCKED);
            if (hbRise)       hbCnt <= '0;
            else if (~&hbCnt) hbCnt <= hbMeas[HB_W-1:0];
            // The edge that leaves LOST has no valid reference to measure from.
            if (hbRise && hbState != LOST)
                evrHeartbeatInterval <= hbMeas[HB_W] ? '1 : hbMeas[HB_W-1:0];
            if (hbState == LOCKED && hbStateNext == LOST && evrHeartbeatLossCount != 8'hFF)
                evrHeartbeatLossCount <= evrHeartbeatLossCount + 8'd1;
        end
    end

    // Ping half-period measurement and lock qualification.
    always_ff @(posedge evrRxClk) begin
        if (evrRxReset) begin
            pCnt              <= '0;
            pGood             <= '0;
            evrPingEdge       <= 1'b0;
            evrPingLocked     <= 1'b0;
            evrPingHalfPeriod <= '0;
        end else begin
            evrPingEdge <= pEdge;
            if (pEdge) begin
                pCnt              <= '0;
                evrPingHalfPeriod <= pMeas[PING_W] ? '1 : pMeas[PING_W-1:0];
                if (pInTol) begin
                    // Lock needs three good transitions already banked.
                    if (pGood == 2'd3) evrPingLocked <= 1'b1;
                    else               pGood <= pGood + 2'd1;
                end else begin
                    pGood         <= '0;
                    evrPingLocked <= 1'b0;
                end
            end else begin
                if (~&pCnt) pCnt <= pMeas[PING_W-1:0];
                if (pTimeout) begin
                    pGood         <= '0;
                    evrPingLocked <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_evr_dbus_monitor.sv
// Randomized bench for evr_dbus_monitor: a generator produces heartbeat,
// ping and diagnostic patterns (with random phase, jitter, valid gaps and
// noise); a timestamp-based reference model predicts every output each cycle.
module tb_evr_dbus_monitor;
    localparam int FREQ      = 125000000;
    localparam int TIMEOUT   = 5000;
    localparam int TOL       = 8;
    localparam int HB_W      = $clog2(FREQ) + 3;
    localparam int PING_HALF = FREQ / 200000;
    localparam int PING_W    = $clog2(PING_HALF) + 2;
    localparam int PSAT      = (1 << PING_W) - 1;

    logic              evrRxClk = 1'b0;
    logic              evrRxReset;
    logic              evrHeartbeatMarker, evrHeartbeatLocked;
    logic [HB_W-1:0]   evrHeartbeatInterval;
    logic [7:0]        evrHeartbeatLossCount;
    logic              evrPing, evrPingEdge, evrPingLocked, evrDiag;
    logic [PING_W-1:0] evrPingHalfPeriod;

    evr_dbus_monitor_if #(.DISTRIBUTED_BUS_WIDTH(8)) dbusIf();

    evr_dbus_monitor #(
        .RXCLK_NOMINAL_FREQUENCY(FREQ),
        .DISTRIBUTED_BUS_WIDTH(8),
        .HB_TIMEOUT_CYCLES(TIMEOUT),
        .PING_TOLERANCE(TOL)
    ) dut (
        .evrRxClk(evrRxClk),
        .evrRxReset(evrRxReset),
        .dbus(dbusIf),
        .evrHeartbeatMarker(evrHeartbeatMarker),
        .evrHeartbeatLocked(evrHeartbeatLocked),
        .evrHeartbeatInterval(evrHeartbeatInterval),
        .evrHeartbeatLossCount(evrHeartbeatLossCount),
        .evrPing(evrPing),
        .evrPingEdge(evrPingEdge),
        .evrPingLocked(evrPingLocked),
        .evrPingHalfPeriod(evrPingHalfPeriod),
        .evrDiag(evrDiag)
    );

    always #5 evrRxClk = ~evrRxClk;

    int checks = 0;
    int errors = 0;
    int t = 0;

    // generator state
    int   hbPer = 0, hbPh = 0, pHalf = 0, pJit = 0, pc = 0, pCur = 625, vMode = 0;
    logic hbLvl = 0, pLvl = 0, diag = 0, rnd = 0, vTog = 0;

    // reference model state (timestamps of last edge / reset)
    logic [7:0] mLat;
    int   hbRef, pRef, hbSeen, mInterval, mLoss, mHalf, run;
    logic mMarker, mPEdge;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at cycle %0d", tag, obs, exp, t);
        end
    endtask

    // Predicts outputs after the upcoming clock edge (edge number t).
    task automatic model(input logic r, input logic v, input logic [7:0] d);
        int el, pel, diff;
        logic rise, pe;
        t++;
        mMarker = 0;
        mPEdge  = 0;
        if (r) begin
            mLat = 0; hbSeen = 0; mInterval = 0; mLoss = 0; mHalf = 0; run = 0;
            hbRef = t; pRef = t;
            return;
        end
        rise = v && d[0] && !mLat[0];
        pe   = v && (d[1] != mLat[1]);
        if (v) mLat = d;
        el = t - hbRef;
        if (rise) begin
            mMarker = 1;
            if (hbSeen > 0) mInterval = el;
            hbSeen = (hbSeen >= 2) ? 2 : hbSeen + 1;
            hbRef  = t;
        end else if (hbSeen > 0 && el >= TIMEOUT) begin
            if (hbSeen == 2 && mLoss < 255) mLoss++;
            hbSeen = 0;
        end
        pel = t - pRef;
        if (pe) begin
            mPEdge = 1;
            mHalf  = (pel > PSAT) ? PSAT : pel;
            diff   = pel - PING_HALF;
            if (diff < 0) diff = -diff;
            if (diff <= TOL) run++;
            else             run = 0;
            pRef = t;
        end else if (pel >= 2 * PING_HALF) begin
            run = 0;
        end
    endtask

    task automatic step(input logic r);
        logic [7:0] d;
        logic v;
        d = 8'($urandom);
        if (!rnd) begin
            if (hbPer != 0) begin
                d[0] = (hbPh < hbPer / 2);
                hbPh = (hbPh + 1) % hbPer;
            end else d[0] = hbLvl;
            if (pHalf != 0) begin
                pc++;
                if (pc >= pCur) begin
                    pLvl = !pLvl;
                    pc   = 0;
                    pCur = pHalf + int'($urandom_range(0, 2 * pJit)) - pJit;
                end
            end
            d[1] = pLvl;
            d[2] = diag;
        end
        case (vMode)
            0:       v = 1'b1;
            1:       begin vTog = !vTog; v = vTog; end
            default: v = 1'($urandom_range(0, 1));
        endcase
        evrRxReset          = r;
        dbusIf.evrDbus      = d;
        dbusIf.evrDbusValid = v;
        model(r, v, d);
        @(negedge evrRxClk);
        chk("latched",  32'(dbusIf.evrDbusLatched), 32'(mLat));
        chk("marker",   32'(evrHeartbeatMarker),    32'(mMarker));
        chk("hbLocked", 32'(evrHeartbeatLocked),    32'(hbSeen == 2));
        chk("interval", 32'(evrHeartbeatInterval),  32'(mInterval));
        chk("loss",     32'(evrHeartbeatLossCount), 32'(mLoss));
        chk("ping",     32'(evrPing),               32'(mLat[1]));
        chk("pEdge",    32'(evrPingEdge),           32'(mPEdge));
        chk("pLocked",  32'(evrPingLocked),         32'(run >= 4));
        chk("half",     32'(evrPingHalfPeriod),     32'(mHalf));
        chk("diag",     32'(evrDiag),               32'(mLat[2]));
    endtask

    initial begin
        evrRxReset          = 1'b1;
        dbusIf.evrDbus      = '0;
        dbusIf.evrDbusValid = 1'b0;
        @(negedge evrRxClk);
        repeat (3) step(1);

        // heartbeat 1000 cycles, ping 625 cycles half-period
        hbPer = 1000; hbPh = $urandom_range(0, 999); pHalf = 625;
        repeat (5000) step(0);
        chk("hb_interval_1000", 32'(evrHeartbeatInterval), 1000);
        chk("hb_locked",        32'(evrHeartbeatLocked), 1);
        chk("ping_half_625",    32'(evrPingHalfPeriod), 625);
        chk("ping_locked",      32'(evrPingLocked), 1);

        // jitter inside tolerance keeps ping lock
        pJit = TOL;
        repeat (3000) step(0);
        chk("ping_jitter_locked", 32'(evrPingLocked), 1);

        // heartbeat stops low; ping moves to 640
        hbPer = 0; hbLvl = 0; pJit = 0; pHalf = 640;
        repeat (6000) step(0);
        chk("hb_lost",       32'(evrHeartbeatLocked), 0);
        chk("hb_loss_1",     32'(evrHeartbeatLossCount), 1);
        chk("ping_640_unlk", 32'(evrPingLocked), 0);
        chk("ping_half_640", 32'(evrPingHalfPeriod), 640);

        // heartbeat restarts; ping back to nominal then stopped
        hbPer = 1000; hbPh = 500; pHalf = 625;
        repeat (3000) step(0);
        chk("hb_relocked",   32'(evrHeartbeatLocked), 1);
        chk("hb_loss_still", 32'(evrHeartbeatLossCount), 1);
        pHalf = 0;
        repeat (2000) step(0);
        chk("ping_stopped", 32'(evrPingLocked), 0);

        // valid gaps: alternate, then random
        vMode = 1; hbPer = 999; hbPh = 0; pHalf = 625;
        repeat (4000) step(0);
        vMode = 2;
        repeat (2000) step(0);

        // edges exactly at the timeout count
        vMode = 0; hbPer = TIMEOUT; hbPh = TIMEOUT / 2;
        repeat (16000) step(0);
        chk("coinc_locked",   32'(evrHeartbeatLocked), 1);
        chk("coinc_interval", 32'(evrHeartbeatInterval), TIMEOUT);
        chk("coinc_loss",     32'(evrHeartbeatLossCount), 1);

        // reset while both locked, diag high
        hbPer = 1000; hbPh = 0;
        repeat (6000) step(0);
        chk("pre_rst_hb",   32'(evrHeartbeatLocked), 1);
        chk("pre_rst_ping", 32'(evrPingLocked), 1);
        diag = 1;
        step(1);
        step(1);
        chk("rst_latched",  32'(dbusIf.evrDbusLatched), 0);
        chk("rst_interval", 32'(evrHeartbeatInterval), 0);
        chk("rst_loss",     32'(evrHeartbeatLossCount), 0);
        chk("rst_half",     32'(evrPingHalfPeriod), 0);
        vMode = 1;
        repeat (20) step(0);
        chk("diag_after_rst", 32'(evrDiag), 1);

        // random bus noise
        rnd = 1; vMode = 2;
        repeat (3000) step(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
